// File: rtl/serial_addsub.sv
// -----------------------------------------------------------------------------
// serial_addsub
//
// Digit-serial adder/subtractor. A WIDTH-bit a+b or a-b is resolved DIGIT bits
// per clock, least-significant digit first, with the ripple carry held in a
// register between digit steps. One operation takes N = WIDTH/DIGIT RUN cycles.
//
// Parameters
//   WIDTH        operand/result width, must be an integer multiple of DIGIT
//   DIGIT        bits resolved per clock
//
// Ports
//   clk          clock, rising edge active
//   rst          asynchronous active-high reset
//   start        request, sampled only while busy=0
//   sub          0: a+b, 1: a-b, sampled with start
//   a, b         operands, sampled with start
//   busy         high while the digit steps are running (exactly N cycles)
//   done         one-cycle pulse, s/cout/ovf/zf were just updated
//   s            result
//   cout         carry out of the MSB (subtract: 1 = no borrow)
//   ovf          signed overflow
//   zf           s == 0
//   dbg_state_o  current FSM state, for debug and checker binding
//
// Handshake: the request is accepted on any rising edge where start=1 and the
// block is in IDLE or DONE (busy=0). A request presented while busy=1 is
// dropped without affecting the operation in flight. done is asserted for the
// single cycle following the last digit step; holding start high in that cycle
// starts the next operation back-to-back.
//
// Configuration macro: SERIAL_ADDSUB_SAT_EN
//   defined   -> on signed overflow s clamps to the signed limit
//   undefined -> s is the wrapped WIDTH-bit result, no clamp logic built
// -----------------------------------------------------------------------------

module serial_addsub #(
    parameter int WIDTH = 32,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf,
    output logic             zf,
    output logic [1:0]       dbg_state_o
);

    // Number of digit steps and width of the step counter.
    localparam int N     = WIDTH / DIGIT;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] opa_q,   opa_d;
    logic [WIDTH-1:0] opb_q,   opb_d;
    logic             carry_q, carry_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic [WIDTH-1:0] res_q,   res_d;
    logic [WIDTH-1:0] s_q,     s_d;
    logic             cout_q,  cout_d;
    logic             ovf_q,   ovf_d;
    logic             zf_q,    zf_d;

    // -------------------------------------------------------------------------
    // Digit adder: the low digit of each shifting operand plus the held carry.
    // -------------------------------------------------------------------------
    logic [DIGIT:0]   dsum;
    logic [DIGIT-1:0] dig;
    logic             dig_c;
    logic             c_into_msb;
    logic [WIDTH-1:0] dig_ext;
    logic [WIDTH-1:0] res_shift;
    logic             cnt_last;
    logic             ovf_next;
    logic [WIDTH-1:0] s_final;

    always_comb begin
        dsum  = {1'b0, opa_q[DIGIT-1:0]}
              + {1'b0, opb_q[DIGIT-1:0]}
              + {{DIGIT{1'b0}}, carry_q};
        dig   = dsum[DIGIT-1:0];
        dig_c = dsum[DIGIT];

        // Carry into the digit's top bit, recovered from its sum bit and the
        // two operand bits. Only meaningful on the last step, where that bit
        // is the word MSB.
        c_into_msb = dsum[DIGIT-1] ^ opa_q[DIGIT-1] ^ opb_q[DIGIT-1];

        // New digit enters at the top; earlier digits move down. Written with
        // shifts so DIGIT == WIDTH needs no zero-width slice.
        dig_ext   = WIDTH'(dig);
        res_shift = (res_q >> DIGIT) | (dig_ext << (WIDTH - DIGIT));

        cnt_last  = (cnt_q == CNT_LAST);
        ovf_next  = c_into_msb ^ dig_c;
    end

    // -------------------------------------------------------------------------
    // Result formatting on the final step.
    // -------------------------------------------------------------------------
`ifdef SERIAL_ADDSUB_SAT_EN
    // On the last step opa_q's low digit holds A's top digit, so
    // opa_q[DIGIT-1] is A's sign. An overflow always has the sign opposite to
    // the true result, whose sign matches A.
    always_comb begin
        s_final = res_shift;
        if (ovf_next) begin
            if (opa_q[DIGIT-1]) begin
                s_final = {1'b1, {(WIDTH-1){1'b0}}};
            end else begin
                s_final = {1'b0, {(WIDTH-1){1'b1}}};
            end
        end
    end
`else
    always_comb begin
        s_final = res_shift;
    end
`endif

    // -------------------------------------------------------------------------
    // FSM and datapath next state
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        s_d     = s_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        zf_d    = zf_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    // Subtract is A + ~B + 1: invert B, seed the carry with 1.
                    opa_d   = a;
                    opb_d   = sub ? ~b : b;
                    carry_d = sub;
                    cnt_d   = '0;
                    res_d   = '0;
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_RUN: begin
                opa_d   = opa_q >> DIGIT;
                opb_d   = opb_q >> DIGIT;
                res_d   = res_shift;
                carry_d = dig_c;
                cnt_d   = cnt_q + CNT_ONE;
                if (cnt_last) begin
                    s_d     = s_final;
                    cout_d  = dig_c;
                    ovf_d   = ovf_next;
                    zf_d    = (s_final == '0);
                    state_d = ST_DONE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            opa_q   <= '0;
            opb_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            res_q   <= '0;
            s_q     <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            zf_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            s_q     <= s_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            zf_q    <= zf_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign busy        = (state_q == ST_RUN);
    assign done        = (state_q == ST_DONE);
    assign s           = s_q;
    assign cout        = cout_q;
    assign ovf         = ovf_q;
    assign zf          = zf_q;
    assign dbg_state_o = state_q;

endmodule
